// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the
// memory controller read port, with fetch-cancel and whole-cache invalidate.
module inst_cache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  input  logic        inv,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        if_busy,
  output logic        inst_re,
  output logic [31:0] inst_raddr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_rbusy
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_busy_q, if_busy_d;
  logic        inst_re_q, inst_re_d;
  logic [31:0] inst_raddr_q, inst_raddr_d;
  logic        drop_q, drop_d;
  logic        inv_pend_q, inv_pend_d;
  logic        seen_busy_q, seen_busy_d;
  logic        wr_en;

  logic [INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;
  logic               unused_addr;

  assign req_idx     = if_addr[INDEX_W+1:2];
  assign req_tag     = if_addr[31:INDEX_W+2];
  assign fill_idx    = inst_raddr_q[INDEX_W+1:2];
  assign fill_tag    = inst_raddr_q[31:INDEX_W+2];
  assign unused_addr = ^if_addr[1:0];

  // A pending invalidate makes the first IDLE cycle miss unconditionally
  assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag)
               && !inv_pend_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    if_valid_d   = if_valid_q;
    if_inst_d    = if_inst_q;
    if_busy_d    = if_busy_q;
    inst_re_d    = inst_re_q;
    inst_raddr_d = inst_raddr_q;
    drop_d       = drop_q;
    inv_pend_d   = inv_pend_q;
    seen_busy_d  = seen_busy_q;
    wr_en        = 1'b0;
    if (rdy) begin
      if_valid_d = 1'b0;
      inst_re_d  = 1'b0;
      unique case (state_q)
        IDLE: begin
          drop_d     = 1'b0;
          inv_pend_d = 1'b0;
          if (inv || inv_pend_q) valid_d = '0;
          if (if_req && !if_flush) begin
            if (hit) begin
              if_valid_d = 1'b1;
              if_inst_d  = data_mem[req_idx];
            end else begin
              inst_raddr_d = {if_addr[31:2], 2'b00};
              inst_re_d    = 1'b1;
              if_busy_d    = 1'b1;
              state_d      = REQ;
            end
          end
        end
        REQ: begin
          seen_busy_d = inst_rbusy;
          drop_d      = drop_q | if_flush;
          inv_pend_d  = inv_pend_q | inv;
          state_d     = WAIT;
        end
        WAIT: begin
          seen_busy_d = seen_busy_q | inst_rbusy;
          drop_d      = drop_q | if_flush;
          inv_pend_d  = inv_pend_q | inv;
          if (seen_busy_q && !inst_rbusy) begin
            wr_en             = 1'b1;
            valid_d[fill_idx] = 1'b1;
            if (!(drop_q || if_flush)) begin
              if_valid_d = 1'b1;
              if_inst_d  = inst_rdata;
            end
            if_busy_d   = 1'b0;
            seen_busy_d = 1'b0;
            drop_d      = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      if_valid_q   <= 1'b0;
      if_inst_q    <= '0;
      if_busy_q    <= 1'b0;
      inst_re_q    <= 1'b0;
      inst_raddr_q <= '0;
      drop_q       <= 1'b0;
      inv_pend_q   <= 1'b0;
      seen_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      if_valid_q   <= if_valid_d;
      if_inst_q    <= if_inst_d;
      if_busy_q    <= if_busy_d;
      inst_re_q    <= inst_re_d;
      inst_raddr_q <= inst_raddr_d;
      drop_q       <= drop_d;
      inv_pend_q   <= inv_pend_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= inst_rdata;
    end
  end

  assign if_valid   = if_valid_q;
  assign if_inst    = if_inst_q;
  assign if_busy    = if_busy_q;
  assign inst_re    = inst_re_q;
  assign inst_raddr = inst_raddr_q;

endmodule
